// File: rtl/uart_tx_periph.sv
// uart_tx_periph: store-bus UART transmitter with a TX FIFO and a registered status readback.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop (8E1); default build is 8N1.
module uart_tx_periph #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [9:0] TX_ADDR      = 10'h54,
    parameter logic [9:0] STAT_ADDR    = 10'h58
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] address,
    input  logic [7:0] data,
    input  logic       write,
    output logic       tx,
    output logic [7:0] read_data,
    output logic       busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_bit_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif
    logic             r_tx;
    logic             r_busy;
    logic [7:0]       r_read_data;

    logic             w_full;
    logic             w_empty;
    logic             w_bit_end;
    logic             w_pop;
    logic             w_tx_wr;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_ovf_clr;
    logic [CNT_W-1:0] w_count_next;
    logic [2:0]       w_state_next;
    logic [7:0]       w_status;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_bit_end = (r_bit_timer == '0);
    // Pop in IDLE, or on the last STOP cycle so back-to-back frames have no gap.
    assign w_pop     = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
    assign w_tx_wr   = write && (address == TX_ADDR);
    // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted then.
    assign w_push    = w_tx_wr && (!w_full || w_pop);
    assign w_ovf_set = w_tx_wr && w_full && !w_pop;
    assign w_ovf_clr = write && (address == STAT_ADDR) && data[3];
    assign w_status  = {4'(r_count), r_overflow, w_empty, w_full, r_busy};

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_next = ST_START;
            ST_START: if (w_bit_end) w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
`endif
            ST_STOP:  if (w_bit_end) w_state_next = w_empty ? ST_IDLE : ST_START;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_state     <= ST_IDLE;
            r_bit_timer <= TMR_LAST;
            r_bit_idx   <= '0;
            r_shift     <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_read_data <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_busy      <= (w_count_next != '0) || (w_state_next != ST_IDLE);
            r_read_data <= (address == STAT_ADDR) ? w_status : 8'h00;

            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);

            if ((r_state == ST_IDLE) || w_bit_end) r_bit_timer <= TMR_LAST;
            else                                   r_bit_timer <= r_bit_timer - TMR_W'(1);

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
                r_tx     <= 1'b0;
            end else begin
                case (r_state)
                    ST_START: begin
                        if (w_bit_end) begin
                            r_tx      <= r_shift[0];
                            r_bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                r_tx <= r_parity;
`else
                                r_tx <= 1'b1;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_shift   <= {1'b0, r_shift[7:1]};
                                r_tx      <= r_shift[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: if (w_bit_end) r_tx <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign read_data = r_read_data;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: expected bytes go into a scoreboard queue on write
// and are popped when the serial frame is decoded from tx. Honors UART_TX_PARITY_EN.
module tb_uart_tx_periph;
    localparam int         CPB   = 4;
    localparam int         DEPTH = 8;
    localparam logic [9:0] TXA   = 10'h54;
    localparam logic [9:0] STA   = 10'h58;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] address = '0;
    logic [7:0] data = '0;
    logic       write = 1'b0;
    logic       tx;
    logic [7:0] read_data;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_tx_periph #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TXA),
        .STAT_ADDR   (STA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data     (data),
        .write    (write),
        .tx       (tx),
        .read_data(read_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write is sampled on the following posedge.
    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        address = a;
        data    = d;
        write   = 1'b1;
        @(negedge clk);
        write   = 1'b0;
        address = '0;
    endtask

    task automatic rd_status(output logic [7:0] s);
        address = STA;
        write   = 1'b0;
        @(negedge clk);
        s = read_data;
        address = '0;
    endtask

    // Waits for the start bit, samples each bit half a cycle after it begins,
    // returns at the stop-bit sample. waits = negedges spent polling for the start.
    task automatic check_frame(input string tag, output int waits);
        logic [7:0] got;
        logic [7:0] exp;
        waits = 0;
        while (tx !== 1'b0 && waits < 400) begin
            @(negedge clk);
            waits++;
        end
        chk($sformatf("%s start", tag), {31'd0, tx}, 32'd0);
        chk($sformatf("%s sb_nonempty", tag), {31'd0, exp_q.size() > 0}, 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            got[k] = tx;
        end
        chk($sformatf("%s data", tag), {24'd0, got}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk($sformatf("%s parity", tag), {31'd0, tx}, {31'd0, ^exp});
`endif
        repeat (CPB) @(negedge clk);
        chk($sformatf("%s stop", tag), {31'd0, tx}, 32'd1);
        $display("frame %s: got=%02h exp=%02h waits=%0d", tag, got, exp, waits);
    endtask

    initial begin
        logic [7:0] st;
        int w;
        int hi_cnt;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst tx", {31'd0, tx}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst read_data", {24'd0, read_data}, 32'h00);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle tx", {31'd0, tx}, 32'd1);
        chk("idle busy", {31'd0, busy}, 32'd0);
        rd_status(st);
        chk("idle status", {24'd0, st}, 32'h04);
        $display("step idle: status=%02h", st);

        // Single byte: latency, bit pattern, busy fall
        exp_q.push_back(8'hA5);
        wr(TXA, 8'hA5);
        chk("a5 busy rise", {31'd0, busy}, 32'd1);
        chk("a5 tx still idle", {31'd0, tx}, 32'd1);
        check_frame("a5", w);
        chk("a5 fall latency", w, 32'd1);
        repeat (CPB - 1) @(negedge clk);
        chk("a5 busy in stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("a5 busy fall", {31'd0, busy}, 32'd0);

        // Ten bytes back-to-back: 0x08 is pushed after the first pop, 0x09 overflows
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if (i < 9) exp_q.push_back(8'(i));
                    wr(TXA, 8'(i));
                end
                rd_status(st);
                chk("ovf status", {24'd0, st}, 32'h8B);
                $display("step overflow: status=%02h", st);
                wr(STA, 8'h08);
                rd_status(st);
                chk("ovf clear status", {24'd0, st}, 32'h83);
                $display("step ovf clear: status=%02h", st);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    check_frame($sformatf("burst%0d", i), w);
                    if (i > 0) chk($sformatf("burst%0d gap", i), w, 32'd4);
                end
            end
        join
        repeat (CPB - 1) @(negedge clk);
        chk("burst busy in stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("burst busy fall", {31'd0, busy}, 32'd0);
        rd_status(st);
        chk("burst drained status", {24'd0, st}, 32'h04);
        chk("burst sb empty", exp_q.size(), 32'd0);

        // Full FIFO, push lands on the STOP->START pop edge
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    exp_q.push_back(8'h30 + 8'(i));
                    wr(TXA, 8'h30 + 8'(i));
                end
                repeat (FRAME_CYC - 9) @(negedge clk);
                rd_status(st);
                chk("full before", {24'd0, st}, 32'h83);
                exp_q.push_back(8'hC3);
                wr(TXA, 8'hC3);
                rd_status(st);
                chk("full push on pop", {24'd0, st}, 32'h83);
                $display("step full push-on-pop: status=%02h", st);
            end
            begin
                for (int i = 0; i < 10; i++) check_frame($sformatf("full%0d", i), w);
            end
        join
        chk("full sb empty", exp_q.size(), 32'd0);
        repeat (2 * CPB) @(negedge clk);

        // Reset mid-DATA with three bytes queued
        wr(TXA, 8'h11);
        wr(TXA, 8'h22);
        wr(TXA, 8'h33);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst tx", {31'd0, tx}, 32'd1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        rd_status(st);
        chk("midrst status", {24'd0, st}, 32'h04);
        hi_cnt = 0;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (tx === 1'b1) hi_cnt++;
        end
        chk("midrst no frames", hi_cnt, 3 * FRAME_CYC);
        $display("step midrst: status=%02h high_cycles=%0d", st, hi_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter on the data-memory store bus, alongside the GPO peripheral. Decodes CPU byte stores to its TX address and queues them in a small FIFO. Serialises each byte as an 8N1 frame (optionally 8E1) on `tx`. Returns a status byte with one-cycle registered latency, matching the data memory read path.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal values ≥ 2.
- `FIFO_DEPTH`, 8, TX FIFO entries; legal values 2, 4, 8.
- `TX_ADDR`, 10'h54, byte address of the TX data register (write-only).
- `STAT_ADDR`, 10'h58, byte address of the status register (read; write clears overflow).
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `address`  in  10  store/load byte address from the CPU.
- `data`  in  8  store data, low byte.
- `write`  in  1  store strobe, sampled at posedge `clk`.
- `tx`  out  1  serial output; idle high.
- `read_data`  out  8  registered status readback.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.

## Operation
- Push: on a posedge with `write & address==TX_ADDR`, `data` is pushed if the FIFO is not full.
- Push when full: the byte is dropped, FIFO is unchanged, and sticky `overflow` is set.
- Overflow clear: `write & address==STAT_ADDR & data[3]` clears `overflow`. Other written bits are ignored.
- Status byte fields:
  - [0] `busy`
  - [1] full
  - [2] empty
  - [3] overflow
  - [7:4] FIFO count, 0..FIFO_DEPTH
- Readback: `read_data` is updated every posedge. It loads the status byte when `address==STAT_ADDR`, otherwise 8'h00.
- FSM states: IDLE, START, DATA, PARITY (only if compiled in), STOP.
  - IDLE: if the FIFO is non-empty at a posedge, pop the head into the shift register, drive `tx`<=0, go to START.
  - START, DATA, PARITY, STOP: each bit is held exactly CLKS_PER_BIT cycles, timed by a down-counter.
  - DATA: 8 bits, LSB first; a bit index counts 0..7.
  - STOP: `tx`=1. On its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Simultaneous push and pop: both take effect in the same cycle and count is unchanged. This holds when full, so a push coinciding with a pop on a full FIFO is accepted.
- Pointers: wrap modulo FIFO_DEPTH. Count has a separate register, width log2(FIFO_DEPTH)+1.
- Reset values: `tx`=1, `read_data`=8'h00, `busy`=0, FIFO empty, `overflow`=0, state IDLE.
- Reset mid-frame: the frame is aborted, `tx` is high after the reset edge, and FIFO contents are discarded.

## Timing
- Write latency: a write sampled at edge N gives count=1 after N. IDLE pops at N+1, so `tx` falls after edge N+1.
- Frame length: 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity). Back-to-back frames have no gap.
- Status latency: a status read sampled at edge N appears on `read_data` after edge N. It reflects state before edge N's updates.
- `busy` is registered. It rises after the edge that accepts a push into an empty idle block. It falls after the edge that ends STOP with the FIFO empty.
- `tx` is driven from a flop: no combinational path from any input.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 8E1.
- Undefined: PARITY state, parity logic and its encoding are absent, and the frame is 8N1.

## Test plan
- Reset release, no writes for 100 cycles -> `tx`=1, `busy`=0, status read = 8'h04.
- CLKS_PER_BIT=4: write 8'hA5 to 10'h54 -> `tx` low from edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 × 4 cycles each, then high 4 cycles. `busy` drops after 40 cycles. With `UART_TX_PARITY_EN`, a parity bit 0 precedes stop.
- Write 10 bytes 8'h00..8'h09 in consecutive cycles (depth 8) -> 8'h00..8'h07 framed back-to-back with no gap. Overflow set and status[3]=1. Byte 8'h09 is never sent; 8'h08 is sent only if pushed after the first pop.
- Overflow set, write 8'h08 to 10'h58 -> next status read has [3]=0 and other fields unchanged.
- Fill FIFO to full, then write exactly on the STOP→START pop edge -> push accepted, count stays 8, overflow stays 0.
- Assert `rst_n`=0 for one cycle mid-DATA with 3 bytes queued -> `tx`=1 next cycle, status 8'h04, no further frames.
